// File: rtl/dot_sequencer.sv
// dot_sequencer: buffers a vector of operand pairs, replays them into an
// external MAC one pair per cycle, and reports the dot product as the MAC
// accumulator value after the replay minus the value captured just before it.
// Real-valued ports use a signed fixed-point word of DATA_W bits. The
// sequencer only moves words and takes one difference, so the position of
// the binary point does not matter here. 0.0 is the all-zero word.
module dot_sequencer #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic signed [DATA_W-1:0] mac_a,
  output logic signed [DATA_W-1:0] mac_b,
  input  logic signed [DATA_W-1:0] acc_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic signed [DATA_W-1:0] res_data,
  output logic [CNT_W-1:0]         res_len,
  output logic                     res_trunc
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_BASE,
    S_ISSUE,
    S_DRAIN,
    S_RESULT
  } state_t;

  state_t                   state;
  logic [CNT_W-1:0]         count;
  logic [CNT_W-1:0]         idx;
  logic signed [DATA_W-1:0] base;
  logic signed [DATA_W-1:0] mem_a [DEPTH];
  logic signed [DATA_W-1:0] mem_b [DEPTH];
  logic                     beat;

  // The downstream accumulator may wrap. A modular difference still gives
  // the correct delta as long as the true sum fits in DATA_W.
  function automatic logic signed [DATA_W-1:0] acc_delta(
    input logic signed [DATA_W-1:0] now_val,
    input logic signed [DATA_W-1:0] start_val
  );
    acc_delta = now_val - start_val;
  endfunction

  assign beat = in_valid && in_ready;

  // Operand buffer: an accepted beat always lands in slot 'count'.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem_a[count[AW-1:0]] <= in_a;
      mem_b[count[AW-1:0]] <= in_b;
    end
  end

  // Sequencer FSM. All outputs are registered. The MAC operands default to
  // 0.0, so the MAC accumulates nothing outside ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      mac_a     <= '0;
      mac_b     <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_len   <= '0;
      res_trunc <= 1'b0;
      count     <= '0;
      idx       <= '0;
      base      <= '0;
    end else begin
      mac_a <= '0;
      mac_b <= '0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (beat) begin
            count <= CNT_W'(1);
            if (in_last) begin
              state    <= S_BASE;
              in_ready <= 1'b0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (beat) begin
            count <= count + CNT_W'(1);
            // A full buffer ends the vector. Without in_last, that is a truncation.
            if (in_last || (count == CNT_W'(DEPTH - 1))) begin
              state     <= S_BASE;
              in_ready  <= 1'b0;
              res_trunc <= !in_last;
            end
          end
        end
        S_BASE: begin
          // Snapshot the accumulator and present slot 0 for the first issue cycle.
          base  <= acc_in;
          mac_a <= mem_a[0];
          mac_b <= mem_b[0];
          idx   <= CNT_W'(1);
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          // 'idx' is the slot to present next. Reaching 'count' means the
          // last pair is on the bus this cycle.
          if (idx == count) begin
            state <= S_DRAIN;
          end else begin
            mac_a <= mem_a[idx[AW-1:0]];
            mac_b <= mem_b[idx[AW-1:0]];
            idx   <= idx + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // The MAC has registered the final product, so acc_in now holds the full sum.
          res_data  <= acc_delta(acc_in, base);
          res_len   <= count;
          res_valid <= 1'b1;
          state     <= S_RESULT;
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            res_trunc <= 1'b0;
            count     <= '0;
            idx       <= '0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_sequencer.sv
// Testbench for dot_sequencer. A behavioural MAC sits downstream of the DUT.
// Expected dot products are computed from the operand lists with real arithmetic.
module tb_dot_sequencer;

  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DATA_W = 32;
  localparam int FRAC   = 16;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a = '0;
  logic signed [DATA_W-1:0] in_b = '0;
  logic                     in_last = 1'b0;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic                     res_valid;
  logic                     res_ready = 1'b1;
  logic signed [DATA_W-1:0] res_data;
  logic [CNT_W-1:0]         res_len;
  logic                     res_trunc;

  // Downstream MAC. It is never reset and starts at 7.0, so the base subtraction matters.
  logic signed [DATA_W-1:0] acc = 32'sh0007_0000;

  int  checks = 0;
  int  errors = 0;
  real va [32];
  real vb [32];

  always #5 clk = ~clk;

  always @(posedge clk)
    acc <= acc + DATA_W'((longint'(mac_a) * longint'(mac_b)) >>> FRAC);

  dot_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .acc_in    (acc),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_len   (res_len),
    .res_trunc (res_trunc)
  );

  function automatic logic signed [DATA_W-1:0] to_fx(input real r);
    return DATA_W'($rtoi(r * 65536.0));
  endfunction

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_mac_a", 64'(mac_a), 64'(0));
    chk("rst_mac_b", 64'(mac_b), 64'(0));
    chk("rst_res_data", 64'(res_data), 64'(0));
    chk("rst_res_len", 64'(res_len), 64'(0));
    chk("rst_res_trunc", 64'(res_trunc), 64'(0));
  endtask

  // Drives n pairs from va/vb. Each call starts and ends just after a negedge.
  task automatic send_vec(input int n, input bit use_last, input bit gaps);
    int guard;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_a     = to_fx(va[i]);
      in_b     = to_fx(vb[i]);
      in_last  = use_last && (i == n - 1);
      guard    = 0;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) bound_fail("in_ready_wait");
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends one vector and checks the result fields, the latency from BASE,
  // and the result handshake.
  task automatic run_vec(input int n, input bit use_last, input bit gaps,
                         input bit hold_extra, input int hold);
    real s;
    int  lat;
    bit  rdy_seen;
    logic signed [DATA_W-1:0] exp_data;
    s = 0.0;
    for (int i = 0; i < n; i++) s += va[i] * vb[i];
    exp_data  = to_fx(s);
    res_ready = (hold == 0);
    send_vec(n, use_last, gaps);
    if (hold_extra) begin
      // A further beat is offered. It must not be taken before IDLE.
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_a     = to_fx(5.0);
      in_b     = to_fx(5.0);
    end
    lat      = 0;
    rdy_seen = 1'b0;
    while (!res_valid && lat < 200) begin
      @(negedge clk);
      lat++;
      if (in_ready) rdy_seen = 1'b1;
    end
    if (lat >= 200) bound_fail("res_valid_wait");
    chk("latency", 64'(lat), 64'(n + 2));
    chk("in_ready_busy", 64'(rdy_seen), 64'(0));
    chk("res_valid", 64'(res_valid), 64'(1));
    chk("res_data", 64'(res_data), 64'(exp_data));
    chk("res_len", 64'(res_len), 64'(n));
    chk("res_trunc", 64'(res_trunc), 64'((n == DEPTH) && !use_last));
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      chk("hold_valid", 64'(res_valid), 64'(1));
      chk("hold_data", 64'(res_data), 64'(exp_data));
      chk("hold_len", 64'(res_len), 64'(n));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      chk("hold_mac_a", 64'(mac_a), 64'(0));
      chk("hold_mac_b", 64'(mac_b), 64'(0));
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("post_res_valid", 64'(res_valid), 64'(0));
    chk("post_in_ready", 64'(in_ready), 64'(1));
    chk("post_trunc_clear", 64'(res_trunc), 64'(0));
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  initial begin
    // Reset state while rst_n is held low.
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'(1));

    // {1,2,3} . {4,5,6} = 32
    va[0] = 1.0; va[1] = 2.0; va[2] = 3.0;
    vb[0] = 4.0; vb[1] = 5.0; vb[2] = 6.0;
    run_vec(3, 1'b1, 1'b0, 1'b0, 0);

    // Single pair 2.5 * -2 = -5
    va[0] = 2.5; vb[0] = -2.0;
    run_vec(1, 1'b1, 1'b0, 1'b0, 0);

    // Full buffer without in_last gives a truncated result of 16.0
    for (int i = 0; i < DEPTH; i++) begin
      va[i] = 1.0;
      vb[i] = 1.0;
    end
    run_vec(DEPTH, 1'b0, 1'b0, 1'b1, 0);

    // Back-to-back vectors with the MAC carrying its sum across them
    va[0] = 1.0; vb[0] = 1.0;
    run_vec(1, 1'b1, 1'b0, 1'b0, 0);
    va[0] = 2.0; vb[0] = 3.0;
    run_vec(1, 1'b1, 1'b0, 1'b0, 0);

    // Result held for 10 cycles by res_ready low
    va[0] = 1.5; va[1] = -0.25; vb[0] = 2.0; vb[1] = 4.0;
    run_vec(2, 1'b1, 1'b0, 1'b0, 10);

    // Random vectors with random lengths, values and input gaps
    for (int v = 0; v < 20; v++) begin
      int n;
      n = int'($urandom_range(1, DEPTH));
      for (int i = 0; i < n; i++) begin
        va[i] = real'(int'($urandom_range(0, 64)) - 32) / 4.0;
        vb[i] = real'(int'($urandom_range(0, 64)) - 32) / 4.0;
      end
      run_vec(n, 1'b1, 1'b1, 1'b0, int'($urandom_range(0, 2)));
    end

    // Reset pulsed in the middle of ISSUE
    for (int i = 0; i < 8; i++) begin
      va[i] = real'(i + 1);
      vb[i] = 0.5;
    end
    send_vec(8, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("issue_mac_a", 64'(mac_a), 64'(to_fx(va[2])));
    chk("issue_mac_b", 64'(mac_b), 64'(to_fx(vb[2])));
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    chk("rst_hold_res_valid", 64'(res_valid), 64'(0));
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("after_rst_no_result", 64'(res_valid), 64'(0));
    end
    va[0] = 3.0; vb[0] = 3.0;
    run_vec(1, 1'b1, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_sequencer.md
DOT_SEQUENCER -- requirements
Module: dot_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning maximum vector length buffered (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default $clog2(DEPTH)+1, meaning width of length counters.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports in_valid input 1 / in_ready output 1: operand-pair handshake.
REQ-006 SHALL have ports in_a, in_b  input  real (svreal format)  operand pair; in_last input 1 marks final pair.
REQ-007 SHALL have ports mac_a, mac_b  output  real  operands driven to downstream MAC a/b.
REQ-008 SHALL have port acc_in  input  real  MAC accumulator out.
REQ-009 SHALL have ports res_valid output 1 / res_ready input 1: result handshake.
REQ-010 SHALL have ports res_data output real (dot product), res_len output CNT_W (pairs used), res_trunc output 1 (vector truncated).

Function
REQ-011 SHALL implement states IDLE, LOAD, BASE, ISSUE, DRAIN, RESULT.
REQ-012 SHALL assert in_ready only in IDLE and LOAD; a beat transfers when in_valid&&in_ready.
REQ-013 IDLE: first transferred beat SHALL be written to buffer slot 0, count=1, go to LOAD (or BASE if in_last).
REQ-014 LOAD: each transfer SHALL write slot count, count+1; in_last or count reaching DEPTH SHALL go to BASE.
REQ-015 Beat DEPTH without in_last SHALL set res_trunc=1; later beats stay unaccepted until next IDLE (in_ready=0 outside IDLE/LOAD).
REQ-016 BASE (1 cycle): SHALL capture acc_in into base register; mac_a/mac_b=0.
REQ-017 ISSUE: SHALL drive buffer slot idx onto mac_a/mac_b for exactly one cycle each, idx 0..count-1, one pair per cycle, no bubbles.
REQ-018 Outside ISSUE, mac_a and mac_b SHALL be 0.0 so the MAC accumulates nothing.
REQ-019 After last issue SHALL enter DRAIN for 1 cycle (MAC registers sum), then capture res_data=acc_in-base, res_len=count, go to RESULT.
REQ-020 RESULT: res_valid=1; res_data/res_len/res_trunc SHALL hold stable until res_valid&&res_ready, then return to IDLE, clearing count and res_trunc.
REQ-021 Latency from BASE entry to res_valid SHALL be count+2 cycles.
REQ-022 Length-1 vector (in_last on first beat) SHALL be legal; res_len=1.
REQ-023 Buffer SHALL be DEPTH-entry pairs; contents after completion are don't-care.
REQ-024 res_valid SHALL be 0 in every state but RESULT; no input combinationally drives any output.

Reset
REQ-025 On rst_n low SHALL asynchronously enter IDLE: in_ready=0 during reset, then 1 in IDLE; mac_a=mac_b=0.0; res_valid=0; res_data=0.0; res_len=0; res_trunc=0; count=idx=0; base=0.0.
REQ-026 Reset mid-operation (any state) SHALL abandon the vector with no result emitted; first beat after release starts a new vector.

Verification
REQ-027 a={1,2,3}, b={4,5,6}, last on 3rd, res_ready=1 -> res_data=32.0, res_len=3, res_trunc=0, res_valid 5 cycles after BASE.
REQ-028 Single pair a=2.5, b=-2, last -> res_data=-5.0, res_len=1.
REQ-029 DEPTH=16 pairs of 1.0x1.0, no in_last -> res_data=16.0, res_len=16, res_trunc=1; in_ready=0 from BASE until IDLE.
REQ-030 Two back-to-back vectors {1x1} then {2x3}, MAC not reset between -> results 1.0 then 6.0 (base subtraction works).
REQ-031 res_ready held 0 for 10 cycles in RESULT -> res_valid, res_data stable, in_ready=0, mac_a/b=0.0; release -> IDLE next cycle.
REQ-032 rst_n pulsed low mid-ISSUE -> all outputs reset values immediately; no res_valid; new vector {3x3} afterwards -> 9.0.
